// File: rtl/mux4a1_sync_pkg.sv
//------------------------------------------------------------------------------
// mux4a1_sync_pkg : select-code encoding shared by the mux4a1_sync slice
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mux4a1_sync_pkg;

   // Bit 0 is the pairwise (A/B, C/D) choice and bit 1 the pair choice.
   typedef enum logic [1:0] {
      SEL_A = 2'b00,
      SEL_B = 2'b01,
      SEL_C = 2'b10,
      SEL_D = 2'b11
   } sel_e;

endpackage

`default_nettype wire

// File: rtl/mux4a1_sync_mux2a1_comb.sv
//------------------------------------------------------------------------------
// mux2a1_comb : purely combinational width-bit 2-to-1 selector, y = s ? b : a
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mux2a1_comb #(
   parameter int width = 4
) (
   input  logic [width-1:0] a,
   input  logic [width-1:0] b,
   input  logic             s,
   output logic [width-1:0] y
);

   assign y = s ? b : a;

endmodule

`default_nettype wire

// File: rtl/mux4a1_sync.sv
//------------------------------------------------------------------------------
// mux4a1_sync : registered 2-to-1 (F1) and 4-to-1 (F2) selectors on shared selects
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mux4a1_sync
   import mux4a1_sync_pkg::*;
#(
   parameter int width = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [width-1:0] A,
   input  logic [width-1:0] B,
   input  logic [width-1:0] C,
   input  logic [width-1:0] D,
   input  logic             s0,
   input  logic             s1,
   output logic [width-1:0] F1,
   output logic [width-1:0] F2
);

   sel_e             w_sel;
   logic [width-1:0] w_sel2;
   logic [width-1:0] w_ab;
   logic [width-1:0] w_cd;
   logic [width-1:0] w_sel4;

   assign w_sel = sel_e'({s1, s0});

   mux2a1_comb #(.width(width)) u_mux_f1 (
      .a (A),
      .b (B),
      .s (w_sel[0]),
      .y (w_sel2)
   );

   // F2 tree: first level picks within each pair, second level picks the pair.
   mux2a1_comb #(.width(width)) u_mux_ab (
      .a (A),
      .b (B),
      .s (w_sel[0]),
      .y (w_ab)
   );

   mux2a1_comb #(.width(width)) u_mux_cd (
      .a (C),
      .b (D),
      .s (w_sel[0]),
      .y (w_cd)
   );

   mux2a1_comb #(.width(width)) u_mux_f2 (
      .a (w_ab),
      .b (w_cd),
      .s (w_sel[1]),
      .y (w_sel4)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         F1 <= '0;
         F2 <= '0;
      end else if (en) begin
         F1 <= w_sel2;
         F2 <= w_sel4;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mux4a1_sync.sv
//------------------------------------------------------------------------------
// tb_mux4a1_sync : randomized and directed checks of mux4a1_sync at width 4 and 8
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mux4a1_sync;

   logic       clk = 1'b0;
   logic       rst, en, s0, s1;
   logic [7:0] A, B, C, D;
   logic [3:0] f1_4, f2_4;
   logic [7:0] f1_8, f2_8;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mux4a1_sync #(.width(4)) dut4 (
      .clk (clk), .rst (rst), .en (en),
      .A (A[3:0]), .B (B[3:0]), .C (C[3:0]), .D (D[3:0]),
      .s0 (s0), .s1 (s1),
      .F1 (f1_4), .F2 (f2_4)
   );

   mux4a1_sync #(.width(8)) dut8 (
      .clk (clk), .rst (rst), .en (en),
      .A (A), .B (B), .C (C), .D (D),
      .s0 (s0), .s1 (s1),
      .F1 (f1_8), .F2 (f2_8)
   );

   // Reference: channels as an array indexed by the select value.
   logic [7:0] ch [4];
   logic [7:0] m1, m2;
   bit         mvalid = 1'b0;

   always @(posedge clk) begin
      ch[0] = A; ch[1] = B; ch[2] = C; ch[3] = D;
      if (rst) begin
         m1 <= 8'h00;
         m2 <= 8'h00;
         mvalid <= 1'b1;
      end else if (en) begin
         m1 <= ch[int'(s0)];
         m2 <= ch[2 * int'(s1) + int'(s0)];
      end
   end

   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (mvalid) begin
         check("model_f1_w8", f1_8, m1);
         check("model_f2_w8", f2_8, m2);
         check("model_f1_w4", {4'h0, f1_4}, {4'h0, m1[3:0]});
         check("model_f2_w4", {4'h0, f2_4}, {4'h0, m2[3:0]});
      end
   end

   task automatic chk_both(input string nm, input logic [7:0] e1, input logic [7:0] e2);
      check({nm, "_f1_w8"}, f1_8, e1);
      check({nm, "_f2_w8"}, f2_8, e2);
      check({nm, "_f1_w4"}, {4'h0, f1_4}, {4'h0, e1[3:0]});
      check({nm, "_f2_w4"}, {4'h0, f2_4}, {4'h0, e2[3:0]});
   endtask

   task automatic drive(input logic [7:0] a, b, c, d, input logic v1, v0, ve, vr);
      A = a; B = b; C = c; D = d; s1 = v1; s0 = v0; en = ve; rst = vr;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] e1_tab [4];
   logic [7:0] e2_tab [4];

   initial begin
      drive(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      e1_tab[0] = 8'd1; e1_tab[1] = 8'd2; e1_tab[2] = 8'd1; e1_tab[3] = 8'd2;
      e2_tab[0] = 8'd1; e2_tab[1] = 8'd2; e2_tab[2] = 8'd3; e2_tab[3] = 8'd4;
      cyc();

      // Reset held for two cycles with live inputs
      drive(8'd1, 8'd2, 8'd3, 8'd4, 1'b1, 1'b1, 1'b1, 1'b1);
      cyc(); cyc();
      chk_both("reset", 8'd0, 8'd0);
      rst = 1'b0;
      cyc();
      chk_both("post_reset", 8'd2, 8'd4);

      // Select sweep
      for (int i = 0; i < 4; i++) begin
         drive(8'd1, 8'd2, 8'd3, 8'd4, i[1], i[0], 1'b1, 1'b0);
         cyc();
         chk_both($sformatf("sweep%0d", i), e1_tab[i], e2_tab[i]);
      end

      // Enable hold
      drive(8'd5, 8'd6, 8'd7, 8'd8, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc();
      chk_both("hold1", 8'd2, 8'd4);
      cyc();
      chk_both("hold2", 8'd2, 8'd4);
      en = 1'b1;
      cyc();
      chk_both("hold_release", 8'd5, 8'd5);

      // F1 isolation from s1, C, D
      for (int i = 0; i < 6; i++) begin
         logic [7:0] c, d;
         c = 8'($urandom);
         d = 8'($urandom);
         drive(8'd9, 8'd2, c, d, i[0], 1'b0, 1'b1, 1'b0);
         cyc();
         chk_both($sformatf("iso%0d", i), 8'd9, i[0] ? c : 8'd9);
      end

      // Reset priority over a deasserted enable
      drive(8'd7, 8'd2, 8'd3, 8'd4, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc();
      chk_both("prio_pre", 8'd7, 8'd7);
      drive(8'd7, 8'd2, 8'd3, 8'd4, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc();
      chk_both("prio_rst", 8'd0, 8'd0);
      rst = 1'b0;
      cyc();
      chk_both("prio_after", 8'd0, 8'd0);
      cyc();
      chk_both("prio_after2", 8'd0, 8'd0);

      // Full-width bus
      drive(8'hAA, 8'h55, 8'hF0, 8'h0F, 1'b1, 1'b1, 1'b1, 1'b0);
      cyc();
      chk_both("width", 8'h55, 8'h0F);

      // A reset pulse between edges must not reach the outputs
      rst = 1'b1;
      #2;
      check("noasync_f1_w8", f1_8, 8'h55);
      check("noasync_f2_w8", f2_8, 8'h0F);
      rst = 1'b0;
      cyc();
      chk_both("noasync_edge", 8'h55, 8'h0F);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         drive(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
               1'($urandom), 1'($urandom),
               ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
         cyc();
      end

      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
